sprite_pixel_pipe: RTL

SPRITE_PIXEL_PIPE -- requirements
Module: sprite_pixel_pipe

---
 rtl/sprite_pixel_pipe_pkg.sv | 12 +
 rtl/sprite_shape_ram.sv | 19 +
 rtl/sprite_pixel_pipe.sv | 76 +++++++
 3 files changed

// File: rtl/sprite_pixel_pipe_pkg.sv
// Shared widths, constants and pipeline types for the sprite pixel pipe.
package sprite_pixel_pipe_pkg;
  localparam int             SPRITE_ADDR_W     = 12;
  localparam int             COLOR_W           = 4;
  localparam logic [3:0]     TRANSPARENT_COLOR = 4'd0;
  localparam int             SHAPE_RAM_DEPTH   = 4096;

  typedef struct packed {
    logic                     hit;
    logic [SPRITE_ADDR_W-1:0] addr;
  } s1_t;
endpackage

// File: rtl/sprite_shape_ram.sv
// 4096x4 shape RAM: one write port, one registered read port, no reset.
module sprite_shape_ram
  import sprite_pixel_pipe_pkg::*;
(
  input  logic                     clk,
  input  logic                     write,
  input  logic [SPRITE_ADDR_W-1:0] waddr,
  input  logic [COLOR_W-1:0]       wdata,
  input  logic [SPRITE_ADDR_W-1:0] raddr,
  output logic [COLOR_W-1:0]       rdata
);
  logic [COLOR_W-1:0] mem [SHAPE_RAM_DEPTH];

  // Read and write in one block: a colliding read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (write) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sprite_pixel_pipe.sv
// Two-stage sprite pixel pipe: priority select, shape RAM lookup, collision flags.
module sprite_pixel_pipe
  import sprite_pixel_pipe_pkg::*;
#(
  parameter int                       NUM_SPRITES     = 4,
  parameter logic [SPRITE_ADDR_W-1:0] COLLISION_INDEX = 12'd64
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_SPRITES-1:0]                 sprite_active_i,
  input  logic [NUM_SPRITES*SPRITE_ADDR_W-1:0]   sprite_address_i,
  input  logic                                   shape_write_i,
  input  logic [SPRITE_ADDR_W-1:0]               shape_addr_i,
  input  logic [COLOR_W-1:0]                     shape_data_i,
  input  logic                                   register_write_i,
  input  logic [SPRITE_ADDR_W-1:0]               register_index_i,
  output logic                                   pixel_valid_o,
  output logic [COLOR_W-1:0]                     pixel_color_o,
  output logic [NUM_SPRITES-1:0]                 collision_o
);
  logic [NUM_SPRITES-1:0][SPRITE_ADDR_W-1:0] addr_v;
  logic [SPRITE_ADDR_W-1:0]                  win_addr;
  logic [NUM_SPRITES-1:0]                    coll_set;
  logic [NUM_SPRITES-1:0]                    others;
  logic                                      coll_clr;
  s1_t                                       s1;
  logic [2:2]                                vld_pipe;
  logic [COLOR_W-1:0]                        rdata;

  assign addr_v   = sprite_address_i;
  assign coll_clr = register_write_i && (register_index_i == COLLISION_INDEX);

  // Walk from the lowest priority upward so sprite 0 overwrites last.
  always_comb begin
    win_addr = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--)
      if (sprite_active_i[k]) win_addr = addr_v[k];
  end

  always_comb begin
    coll_set = '0;
    others   = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      others      = sprite_active_i;
      others[k]   = 1'b0;
      coll_set[k] = sprite_active_i[k] & (|others);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1          <= '0;
      vld_pipe    <= '0;
      collision_o <= '0;
    end else begin
      s1.hit      <= |sprite_active_i;
      s1.addr     <= win_addr;
      vld_pipe[2] <= s1.hit;
      // A clear in the same cycle as a new overlap keeps the new bits.
      collision_o <= coll_clr ? coll_set : (collision_o | coll_set);
    end
  end

  sprite_shape_ram u_ram (
    .clk   (clk),
    .write (shape_write_i),
    .waddr (shape_addr_i),
    .wdata (shape_data_i),
    .raddr (s1.addr),
    .rdata (rdata)
  );

  // The winner's colour decides alone; transparency never exposes a lower sprite.
  assign pixel_valid_o = vld_pipe[2] && (rdata != TRANSPARENT_COLOR);
  assign pixel_color_o = pixel_valid_o ? rdata : TRANSPARENT_COLOR;
endmodule
